// File: rtl/irrigation_pkg.sv
// Shared constants for the irrigation controller front end:
// debounce default, channel indices and debounce FSM encoding.
package irrigation_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT = 50000;
   localparam int unsigned SENSOR_COUNT     = 7;

   localparam int CH_LOW_WATER  = 0;
   localparam int CH_MID_WATER  = 1;
   localparam int CH_HIGH_WATER = 2;
   localparam int CH_EARTH_HUM  = 3;
   localparam int CH_AIR_HUM    = 4;
   localparam int CH_LOW_TEMP   = 5;
   localparam int CH_SELECTOR   = 6;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_COUNTING = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One raw input: 2-flop synchroniser, debounce counter/FSM and
// the settled output level with a change strobe.
module debounce_channel
   import irrigation_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_changed,
   output logic o_counting
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_changed;
   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;

   logic w_diff;
   logic w_done;

   // Candidate is judged against the output, so a bounce restarts qualification
   assign w_diff = (r_s2 != r_level);
   assign w_done = (r_state == ST_COUNTING) && w_diff && (r_cnt == LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_level   <= 1'b0;
         r_changed <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
      end else begin
         r_s1      <= i_raw;
         r_s2      <= r_s1;
         r_changed <= w_done;
         unique case (r_state)
            ST_IDLE: begin
               if (w_diff) begin
                  r_state <= ST_COUNTING;
                  r_cnt   <= CW'(1);
               end
            end
            ST_COUNTING: begin
               if (!w_diff) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (w_done) begin
                  r_level <= r_s2;
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_level    = r_level;
   assign o_changed  = r_changed;
   assign o_counting = (r_state == ST_COUNTING);

endmodule

// File: rtl/sensor_input_conditioner.sv
// Debounces the seven raw field inputs and derives the
// change strobe, selector press strobe and settled flag.
module sensor_input_conditioner
   import irrigation_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw_low_water_level,
   input  logic raw_mid_water_level,
   input  logic raw_high_water_level,
   input  logic raw_earth_humidity,
   input  logic raw_air_humidity,
   input  logic raw_low_temperature,
   input  logic raw_selector,
   output logic low_water_level,
   output logic mid_water_level,
   output logic high_water_level,
   output logic earth_humidity,
   output logic air_humidity,
   output logic low_temperature,
   output logic selector,
   output logic selector_pulse,
   output logic sensors_changed,
   output logic stable
);

   logic [SENSOR_COUNT-1:0] w_raw;
   logic [SENSOR_COUNT-1:0] w_level;
   logic [SENSOR_COUNT-1:0] w_changed;
   logic [SENSOR_COUNT-1:0] w_counting;
   logic [1:0]              r_startup;

   assign w_raw[CH_LOW_WATER]  = raw_low_water_level;
   assign w_raw[CH_MID_WATER]  = raw_mid_water_level;
   assign w_raw[CH_HIGH_WATER] = raw_high_water_level;
   assign w_raw[CH_EARTH_HUM]  = raw_earth_humidity;
   assign w_raw[CH_AIR_HUM]    = raw_air_humidity;
   assign w_raw[CH_LOW_TEMP]   = raw_low_temperature;
   assign w_raw[CH_SELECTOR]   = raw_selector;

   for (genvar g = 0; g < SENSOR_COUNT; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clock     (clock),
         .reset_n   (reset_n),
         .i_raw     (w_raw[g]),
         .o_level   (w_level[g]),
         .o_changed (w_changed[g]),
         .o_counting(w_counting[g])
      );
   end

   // Hold stable low until the synchronisers have been filled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_startup <= 2'd0;
      end else if (r_startup != 2'd2) begin
         r_startup <= r_startup + 2'd1;
      end
   end

   assign low_water_level  = w_level[CH_LOW_WATER];
   assign mid_water_level  = w_level[CH_MID_WATER];
   assign high_water_level = w_level[CH_HIGH_WATER];
   assign earth_humidity   = w_level[CH_EARTH_HUM];
   assign air_humidity     = w_level[CH_AIR_HUM];
   assign low_temperature  = w_level[CH_LOW_TEMP];
   assign selector         = w_level[CH_SELECTOR];

   assign sensors_changed = |w_changed;
   assign selector_pulse  = w_changed[CH_SELECTOR] & w_level[CH_SELECTOR];
   assign stable          = (r_startup == 2'd2) & ~(|w_counting);

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Scoreboard bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4:
// expected output snapshots are queued per cycle and compared on negedge.
module tb_sensor_input_conditioner;

   localparam logic [9:0] B_LOW  = 10'h001;
   localparam logic [9:0] B_MID  = 10'h002;
   localparam logic [9:0] B_HIGH = 10'h004;
   localparam logic [9:0] B_EAR  = 10'h008;
   localparam logic [9:0] B_AIR  = 10'h010;
   localparam logic [9:0] B_SEL  = 10'h040;
   localparam logic [9:0] B_CHG  = 10'h080;
   localparam logic [9:0] B_PUL  = 10'h100;
   localparam logic [9:0] B_STB  = 10'h200;
   localparam logic [9:0] M_ALL  = 10'h3FF;

   typedef struct {
      int         cyc;
      string      tag;
      logic [9:0] mask;
      logic [9:0] exp;
   } sb_item_t;

   logic clock = 1'b0;
   logic reset_n;
   logic raw_low_water_level, raw_mid_water_level, raw_high_water_level;
   logic raw_earth_humidity, raw_air_humidity, raw_low_temperature;
   logic raw_selector;
   logic low_water_level, mid_water_level, high_water_level;
   logic earth_humidity, air_humidity, low_temperature;
   logic selector, selector_pulse, sensors_changed, stable;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   sb_item_t   sb_q[$];
   logic [9:0] obs_v;

   sensor_input_conditioner #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .raw_low_water_level (raw_low_water_level),
      .raw_mid_water_level (raw_mid_water_level),
      .raw_high_water_level(raw_high_water_level),
      .raw_earth_humidity  (raw_earth_humidity),
      .raw_air_humidity    (raw_air_humidity),
      .raw_low_temperature (raw_low_temperature),
      .raw_selector        (raw_selector),
      .low_water_level     (low_water_level),
      .mid_water_level     (mid_water_level),
      .high_water_level    (high_water_level),
      .earth_humidity      (earth_humidity),
      .air_humidity        (air_humidity),
      .low_temperature     (low_temperature),
      .selector            (selector),
      .selector_pulse      (selector_pulse),
      .sensors_changed     (sensors_changed),
      .stable              (stable)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [9:0] obs,
                        input logic [9:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic expect_at(input int dt, input string tag,
                            input logic [9:0] mask, input logic [9:0] exp);
      sb_item_t it;
      it.cyc  = cyc + dt;
      it.tag  = tag;
      it.mask = mask;
      it.exp  = exp & mask;
      sb_q.push_back(it);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   always @(negedge clock) begin
      obs_v = {stable, selector_pulse, sensors_changed, selector,
               low_temperature, air_humidity, earth_humidity,
               high_water_level, mid_water_level, low_water_level};
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check(sb_q[i].tag, obs_v & sb_q[i].mask, sb_q[i].exp);
            sb_q.delete(i);
         end
      end
   end

   initial begin
      reset_n              = 1'b0;
      raw_low_water_level  = 1'b1;
      raw_mid_water_level  = 1'b1;
      raw_high_water_level = 1'b1;
      raw_earth_humidity   = 1'b1;
      raw_air_humidity     = 1'b1;
      raw_low_temperature  = 1'b1;
      raw_selector         = 1'b1;

      // reset with all raw inputs high, then release
      tick(2);
      expect_at(1, "rst_hold", M_ALL, 10'h000);
      tick(3);
      reset_n = 1'b1;
      expect_at(1, "rst_boot", B_STB, 10'h000);
      expect_at(4, "rst_count", M_ALL, 10'h000);
      expect_at(5, "rst_pre", M_ALL, 10'h000);
      expect_at(6, "rst_flip", M_ALL, 10'h3FF);
      expect_at(7, "rst_post", M_ALL, 10'h27F);
      tick(10);

      // all channels fall together; selector 1->0 gives no pulse
      {raw_low_water_level, raw_mid_water_level, raw_high_water_level,
       raw_earth_humidity, raw_air_humidity, raw_low_temperature,
       raw_selector} = 7'b0;
      expect_at(5, "fall_pre", M_ALL, 10'h07F);
      expect_at(6, "fall_flip", M_ALL, 10'h280);
      expect_at(7, "fall_post", M_ALL, 10'h200);
      tick(10);

      // clean single edge
      raw_high_water_level = 1'b1;
      expect_at(2, "clean_st_hi", B_STB, B_STB);
      expect_at(3, "clean_st_lo", B_STB | B_HIGH, 10'h000);
      expect_at(5, "clean_pre", M_ALL, 10'h000);
      expect_at(6, "clean_flip", M_ALL, 10'h284);
      expect_at(7, "clean_post", M_ALL, 10'h204);
      tick(10);

      // glitch: 3 cycles high is rejected
      raw_earth_humidity = 1'b1;
      expect_at(4, "glitch_cnt", B_STB, 10'h000);
      expect_at(6, "glitch_rej6", B_EAR | B_CHG, 10'h000);
      expect_at(7, "glitch_rej7", B_EAR | B_CHG, 10'h000);
      expect_at(9, "glitch_idle", M_ALL, 10'h204);
      tick(3);
      raw_earth_humidity = 1'b0;
      tick(10);

      // exactly 4 cycles high is accepted, then returns to 0
      raw_earth_humidity = 1'b1;
      expect_at(5, "long_pre", B_EAR | B_CHG, 10'h000);
      expect_at(6, "long_acc", M_ALL, 10'h28C);
      expect_at(10, "long_back", B_EAR | B_CHG, B_CHG);
      tick(4);
      raw_earth_humidity = 1'b0;
      tick(12);

      // selector press and release
      raw_selector = 1'b1;
      expect_at(5, "sel_pre", B_SEL | B_PUL | B_CHG, 10'h000);
      expect_at(6, "sel_rise", B_SEL | B_PUL | B_CHG, B_SEL | B_PUL | B_CHG);
      expect_at(7, "sel_hold", B_SEL | B_PUL | B_CHG, B_SEL);
      tick(10);
      raw_selector = 1'b0;
      expect_at(6, "sel_fall", B_SEL | B_PUL | B_CHG, B_CHG);
      expect_at(7, "sel_idle", B_SEL | B_PUL | B_CHG, 10'h000);
      tick(10);

      // simultaneous rise on two channels
      raw_low_water_level = 1'b1;
      raw_mid_water_level = 1'b1;
      expect_at(5, "simul_pre", B_LOW | B_MID | B_CHG, 10'h000);
      expect_at(6, "simul_flip", B_LOW | B_MID | B_CHG, B_LOW | B_MID | B_CHG);
      expect_at(7, "simul_post", B_LOW | B_MID | B_CHG, B_LOW | B_MID);
      tick(10);

      // reset pulse in the middle of qualification
      raw_air_humidity = 1'b1;
      expect_at(4, "mcr_cnt", B_STB | B_AIR, 10'h000);
      tick(4);
      reset_n = 1'b0;
      expect_at(1, "mcr_rst", B_AIR | B_CHG | B_STB | B_LOW, 10'h000);
      tick(2);
      reset_n = 1'b1;
      expect_at(1, "mcr_boot", B_STB | B_AIR, 10'h000);
      expect_at(5, "mcr_pre", B_AIR, 10'h000);
      expect_at(6, "mcr_acc", B_AIR, B_AIR);
      tick(12);

      while (sb_q.size() > 0) begin
         check({"missed_", sb_q[0].tag}, 10'h000, 10'h3FF);
         void'(sb_q.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
